// File: rtl/alu_stack_sequencer.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// alu_stack_sequencer
//
// Operand-stack controller for the stack machine. Keeps a LIFO of 16-bit
// operands and sequences the shared combinational alu16b: ALU commands pop
// their operands, present A/B/op to the ALU for one cycle (EXEC), then write
// the result back and pulse done (WB).
//
// Ports
//   CLK, RESET_n        clock (rising edge), synchronous active-low reset
//   cmd_valid/ready     command handshake; cmd_ready is high only in IDLE
//   cmd_kind            0=PUSH 1=POP 2=ALU 3=DUP
//   cmd_aluop/cmd_imm   ALU opcode / PUSH value, sampled at acceptance only
//   alu_A/B/op          registered operands and opcode to the ALU
//   alu_S/zero/ofl      ALU result and status, captured at the end of EXEC
//   tos, depth          top of stack (0 when empty), entry count 0..DEPTH
//   done, err           one-cycle completion / rejection pulses
//   err_code            0 none, 1 underflow, 2 overflow, 3 illegal op / trap
//   zero_flag/ofl_flag  last ALU IsZero / OFL, held
//
// Build option
//   ALU_OFL_TRAP_EN     when defined, an ALU result with OFL set is dropped
//                       (stack untouched) and reported as err_code 3.
// ---------------------------------------------------------------------------
module alu_stack_sequencer #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic             CLK,
  input  logic             RESET_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_kind,
  input  logic [3:0]       cmd_aluop,
  input  logic [15:0]      cmd_imm,
  output logic [15:0]      alu_A,
  output logic [15:0]      alu_B,
  output logic [3:0]       alu_op,
  input  logic [15:0]      alu_S,
  input  logic             alu_zero,
  input  logic             alu_ofl,
  output logic [15:0]      tos,
  output logic [PTR_W:0]   depth,
  output logic             done,
  output logic             err,
  output logic [1:0]       err_code,
  output logic             zero_flag,
  output logic             ofl_flag
);

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_t;

  localparam logic [1:0] K_PUSH = 2'd0;
  localparam logic [1:0] K_POP  = 2'd1;
  localparam logic [1:0] K_ALU  = 2'd2;
  localparam logic [1:0] K_DUP  = 2'd3;

  localparam logic [1:0] E_NONE  = 2'd0;
  localparam logic [1:0] E_UNDER = 2'd1;
  localparam logic [1:0] E_OVER  = 2'd2;
  localparam logic [1:0] E_ILL   = 2'd3;

  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0] CNT_TWO  = (PTR_W+1)'(2);

  function automatic logic op_is_binary(input logic [3:0] op);
    return (op <= 4'd6);
  endfunction

  function automatic logic op_is_unary(input logic [3:0] op);
    return (op == 4'd7) || (op == 4'd9);
  endfunction

  // Classify a command against the current depth. Illegal opcodes are
  // reported before any depth check since they have no operand count.
  function automatic logic [1:0] check_cmd(input logic [1:0]     kind,
                                           input logic [3:0]     op,
                                           input logic [PTR_W:0] cnt);
    logic [1:0] code;
    code = E_NONE;
    case (kind)
      K_PUSH: if (cnt == CNT_FULL) code = E_OVER;
      K_POP:  if (cnt == '0) code = E_UNDER;
      K_DUP: begin
        if (cnt == '0)           code = E_UNDER;
        else if (cnt == CNT_FULL) code = E_OVER;
      end
      default: begin
        if (op_is_binary(op)) begin
          if (cnt < CNT_TWO) code = E_UNDER;
        end else if (op_is_unary(op)) begin
          if (cnt == '0) code = E_UNDER;
        end else begin
          code = E_ILL;
        end
      end
    endcase
    return code;
  endfunction

  state_t state_q, state_d;

  logic signed [DATA_W-1:0] stk [DEPTH];
  logic        [PTR_W:0]    cnt;
  logic        [DATA_W-1:0] tos_q;
  logic                     bin_p1;   // in-flight ALU op takes two operands

  logic             accept;
  logic [1:0]       chk;
  logic             trap;
  logic [PTR_W-1:0] idx_top, idx_nos, idx_free;

  assign tos   = tos_q;
  assign depth = cnt;

`ifdef ALU_OFL_TRAP_EN
  assign trap = alu_ofl;
`else
  assign trap = 1'b0;
`endif

  // Slot indices; only used when the depth checks guarantee they are valid.
  assign idx_top  = PTR_W'(cnt - CNT_ONE);
  assign idx_nos  = PTR_W'(cnt - CNT_TWO);
  assign idx_free = PTR_W'(cnt);

  always_comb begin
    accept  = cmd_valid && cmd_ready;
    chk     = check_cmd(cmd_kind, cmd_aluop, cnt);
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept && (chk == E_NONE) && (cmd_kind == K_ALU)) state_d = S_EXEC;
      S_EXEC: state_d = S_WB;
      S_WB:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Stack storage: no reset, contents beyond depth are don't-care.
  always_ff @(posedge CLK) begin
    if (RESET_n) begin
      if ((state_q == S_IDLE) && accept && (chk == E_NONE)) begin
        if (cmd_kind == K_PUSH)     stk[idx_free] <= cmd_imm;
        else if (cmd_kind == K_DUP) stk[idx_free] <= tos_q;
      end else if ((state_q == S_EXEC) && !trap) begin
        if (bin_p1) stk[idx_nos] <= alu_S;
        else        stk[idx_top] <= alu_S;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      cmd_ready <= 1'b0;
      cnt       <= '0;
      tos_q     <= '0;
      alu_A     <= '0;
      alu_B     <= '0;
      alu_op    <= '0;
      bin_p1    <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_code  <= E_NONE;
      zero_flag <= 1'b0;
      ofl_flag  <= 1'b0;
    end else begin
      cmd_ready <= (state_d == S_IDLE);
      done      <= 1'b0;
      err       <= 1'b0;
      case (state_q)
        // Acceptance: stack ops complete here, ALU ops latch operands.
        S_IDLE: begin
          if (accept) begin
            if (chk != E_NONE) begin
              done     <= 1'b1;
              err      <= 1'b1;
              err_code <= chk;
            end else begin
              case (cmd_kind)
                K_PUSH: begin
                  cnt      <= cnt + CNT_ONE;
                  tos_q    <= cmd_imm;
                  done     <= 1'b1;
                  err_code <= E_NONE;
                end
                K_POP: begin
                  cnt      <= cnt - CNT_ONE;
                  tos_q    <= (cnt >= CNT_TWO) ? stk[idx_nos] : '0;
                  done     <= 1'b1;
                  err_code <= E_NONE;
                end
                K_DUP: begin
                  cnt      <= cnt + CNT_ONE;
                  done     <= 1'b1;
                  err_code <= E_NONE;
                end
                default: begin
                  bin_p1 <= op_is_binary(cmd_aluop);
                  alu_op <= cmd_aluop;
                  if (op_is_binary(cmd_aluop)) begin
                    alu_A <= stk[idx_nos];
                    alu_B <= tos_q;
                  end else begin
                    alu_A <= tos_q;
                    alu_B <= '0;
                  end
                end
              endcase
            end
          end
        end
        // EXEC -> WB: capture the settled ALU result and flags.
        S_EXEC: begin
          zero_flag <= alu_zero;
          ofl_flag  <= alu_ofl;
          done      <= 1'b1;
          if (trap) begin
            err      <= 1'b1;
            err_code <= E_ILL;
          end else begin
            err_code <= E_NONE;
            tos_q    <= alu_S;
            if (bin_p1) cnt <= cnt - CNT_ONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_stack_sequencer.sv
`timescale 1ns/1ps
module tb_alu_stack_sequencer;

  localparam logic [1:0] K_PUSH = 2'd0;
  localparam logic [1:0] K_POP  = 2'd1;
  localparam logic [1:0] K_ALU  = 2'd2;
  localparam logic [1:0] K_DUP  = 2'd3;

  logic        CLK = 1'b0;
  logic        RESET_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_kind;
  logic [3:0]  cmd_aluop;
  logic [15:0] cmd_imm;
  logic [15:0] alu_A, alu_B, alu_S;
  logic [3:0]  alu_op;
  logic        alu_zero, alu_ofl;
  logic [15:0] tos;
  logic [3:0]  depth;
  logic        done, err;
  logic [1:0]  err_code;
  logic        zero_flag, ofl_flag;

  alu_stack_sequencer #(.DEPTH(8), .PTR_W(3)) dut (
    .CLK(CLK), .RESET_n(RESET_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_kind(cmd_kind), .cmd_aluop(cmd_aluop), .cmd_imm(cmd_imm),
    .alu_A(alu_A), .alu_B(alu_B), .alu_op(alu_op),
    .alu_S(alu_S), .alu_zero(alu_zero), .alu_ofl(alu_ofl),
    .tos(tos), .depth(depth), .done(done), .err(err), .err_code(err_code),
    .zero_flag(zero_flag), .ofl_flag(ofl_flag)
  );

  always #5 CLK = ~CLK;

  // Stand-in for the combinational alu16b.
  always_comb begin
    alu_S   = 16'h0000;
    alu_ofl = 1'b0;
    case (alu_op)
      4'd0: begin alu_S = alu_A + alu_B; alu_ofl = (alu_A[15] == alu_B[15]) && (alu_S[15] != alu_A[15]); end
      4'd1: begin alu_S = alu_A - alu_B; alu_ofl = (alu_A[15] != alu_B[15]) && (alu_S[15] != alu_A[15]); end
      4'd2: alu_S = alu_A << alu_B[3:0];
      4'd3: alu_S = alu_A >> alu_B[3:0];
      4'd4: alu_S = alu_A & alu_B;
      4'd5: alu_S = alu_A | alu_B;
      4'd6: alu_S = alu_A ^ alu_B;
      4'd7: alu_S = ~alu_A;
      4'd9: begin alu_S = 16'h0000 - alu_A; alu_ofl = (alu_A == 16'h8000); end
      default: alu_S = 16'h0000;
    endcase
    alu_zero = (alu_S == 16'h0000);
  end

  typedef struct packed {
    int          cyc;
    logic        e;
    logic [1:0]  code;
    logic [15:0] tos;
    logic [3:0]  dep;
    logic        chkf;
    logic        zf;
    logic        of;
  } exp_t;

  exp_t  sbq[$];
  string nmq[$];
  int    cyc = 0;
  int    tests = 0;
  int    fails = 0;
  exp_t  mx;
  string mnm;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expectation.
  always @(negedge CLK) begin
    if (RESET_n === 1'b1 && done === 1'b1) begin
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL spurious_done: got done=1 at cycle %0d, expected no completion", cyc);
      end else begin
        mx  = sbq.pop_front();
        mnm = nmq.pop_front();
        chk({mnm, ".cycle"},    cyc, mx.cyc);
        chk({mnm, ".err"},      32'(err), 32'(mx.e));
        chk({mnm, ".err_code"}, 32'(err_code), 32'(mx.code));
        chk({mnm, ".tos"},      32'(tos), 32'(mx.tos));
        chk({mnm, ".depth"},    32'(depth), 32'(mx.dep));
        if (mx.chkf) begin
          chk({mnm, ".zero_flag"}, 32'(zero_flag), 32'(mx.zf));
          chk({mnm, ".ofl_flag"},  32'(ofl_flag), 32'(mx.of));
        end
      end
    end
  end

  task automatic push_exp(input int c, input logic e, input logic [1:0] code,
                          input logic [15:0] t, input int d, input logic chkf,
                          input logic zf, input logic of, input string nm);
    exp_t x;
    x.cyc = c; x.e = e; x.code = code; x.tos = t; x.dep = 4'(d);
    x.chkf = chkf; x.zf = zf; x.of = of;
    sbq.push_back(x);
    nmq.push_back(nm);
  endtask

  // Drive one command; lat = cycles from acceptance edge to the sampled done.
  task automatic issue(input logic [1:0] kind, input logic [3:0] op, input logic [15:0] imm,
                       input int lat, input logic e, input logic [1:0] code,
                       input logic [15:0] t, input int d, input logic chkf,
                       input logic zf, input logic of, input string nm, input bit want);
    int tries;
    tries = 0;
    @(negedge CLK);
    while (cmd_ready !== 1'b1 && tries < 20) begin
      @(negedge CLK);
      tries++;
    end
    if (cmd_ready !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL %s.ready_timeout: got cmd_ready=%0b, expected 1", nm, cmd_ready);
    end else begin
      cmd_valid = 1'b1;
      cmd_kind  = kind;
      cmd_aluop = op;
      cmd_imm   = imm;
      if (want) push_exp(cyc + lat, e, code, t, d, chkf, zf, of, nm);
      @(posedge CLK);
      #1;
      cmd_valid = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    RESET_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_kind  = K_PUSH;
    cmd_aluop = 4'd0;
    cmd_imm   = 16'h0000;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst.cmd_ready", 32'(cmd_ready), 0);
    chk("rst.tos",       32'(tos), 0);
    chk("rst.depth",     32'(depth), 0);
    chk("rst.done",      32'(done), 0);
    chk("rst.err",       32'(err), 0);
    chk("rst.err_code",  32'(err_code), 0);
    chk("rst.flags",     {30'd0, zero_flag, ofl_flag}, 0);
    chk("rst.alu_regs",  {alu_A, alu_B} ^ 32'(alu_op), 0);
    RESET_n = 1'b1;
    @(posedge CLK);
    #1;
    chk("rst.ready_after_release", 32'(cmd_ready), 1);

    // 500 - 600
    issue(K_PUSH, 4'd0, 16'd500, 1, 0, 0, 16'd500, 1, 0, 0, 0, "push500", 1);
    issue(K_PUSH, 4'd0, 16'd600, 1, 0, 0, 16'd600, 2, 0, 0, 0, "push600", 1);
    issue(K_ALU,  4'd1, 16'h0,   2, 0, 0, 16'hFF9C, 1, 1, 0, 0, "sub", 1);
    issue(K_POP,  4'd0, 16'h0,   1, 0, 0, 16'h0000, 0, 0, 0, 0, "pop_sub", 1);

    // 0x7FFF + 1 overflow
    issue(K_PUSH, 4'd0, 16'h7FFF, 1, 0, 0, 16'h7FFF, 1, 0, 0, 0, "push7fff", 1);
    issue(K_PUSH, 4'd0, 16'h0001, 1, 0, 0, 16'h0001, 2, 0, 0, 0, "push1", 1);
`ifdef ALU_OFL_TRAP_EN
    issue(K_ALU,  4'd0, 16'h0,    2, 1, 3, 16'h0001, 2, 1, 0, 1, "add_ofl_trap", 1);
    issue(K_POP,  4'd0, 16'h0,    1, 0, 0, 16'h7FFF, 1, 0, 0, 0, "pop_trap1", 1);
    issue(K_POP,  4'd0, 16'h0,    1, 0, 0, 16'h0000, 0, 0, 0, 0, "pop_trap2", 1);
`else
    issue(K_ALU,  4'd0, 16'h0,    2, 0, 0, 16'h8000, 1, 1, 0, 1, "add_ofl", 1);
    issue(K_POP,  4'd0, 16'h0,    1, 0, 0, 16'h0000, 0, 0, 0, 0, "pop_ofl", 1);
`endif

    // unary ops
    issue(K_PUSH, 4'd0, 16'd7000, 1, 0, 0, 16'd7000, 1, 0, 0, 0, "push7000", 1);
    issue(K_ALU,  4'd9, 16'h0,    2, 0, 0, 16'hE4A8, 1, 1, 0, 0, "neg", 1);
    issue(K_PUSH, 4'd0, 16'hFFFF, 1, 0, 0, 16'hFFFF, 2, 0, 0, 0, "pushffff", 1);
    issue(K_ALU,  4'd7, 16'h0,    2, 0, 0, 16'h0000, 2, 1, 1, 0, "not", 1);
    issue(K_POP,  4'd0, 16'h0,    1, 0, 0, 16'hE4A8, 1, 0, 0, 0, "pop_not", 1);
    issue(K_POP,  4'd0, 16'h0,    1, 0, 0, 16'h0000, 0, 0, 0, 0, "pop_neg", 1);

    // DUP and operand ordering
    issue(K_PUSH, 4'd0, 16'h1234, 1, 0, 0, 16'h1234, 1, 0, 0, 0, "push1234", 1);
    issue(K_DUP,  4'd5, 16'h0,    1, 0, 0, 16'h1234, 2, 0, 0, 0, "dup", 1);
    issue(K_ALU,  4'd4, 16'h0,    2, 0, 0, 16'h1234, 1, 1, 0, 0, "and", 1);
    issue(K_POP,  4'd0, 16'h0,    1, 0, 0, 16'h0000, 0, 0, 0, 0, "pop_and", 1);
    issue(K_PUSH, 4'd0, 16'h0001, 1, 0, 0, 16'h0001, 1, 0, 0, 0, "push_a", 1);
    issue(K_PUSH, 4'd0, 16'h0004, 1, 0, 0, 16'h0004, 2, 0, 0, 0, "push_b", 1);
    issue(K_ALU,  4'd2, 16'h0,    2, 0, 0, 16'h0010, 1, 1, 0, 0, "sll", 1);
    issue(K_POP,  4'd0, 16'h0,    1, 0, 0, 16'h0000, 0, 0, 0, 0, "pop_sll", 1);

    // underflow and illegal ops
    issue(K_ALU,  4'd0, 16'h0,    1, 1, 1, 16'h0000, 0, 1, 0, 0, "add_empty", 1);
    issue(K_POP,  4'd0, 16'h0,    1, 1, 1, 16'h0000, 0, 0, 0, 0, "pop_empty", 1);
    issue(K_DUP,  4'd0, 16'h0,    1, 1, 1, 16'h0000, 0, 0, 0, 0, "dup_empty", 1);
    issue(K_ALU,  4'd7, 16'h0,    1, 1, 1, 16'h0000, 0, 0, 0, 0, "not_empty", 1);
    issue(K_PUSH, 4'd0, 16'h0003, 1, 0, 0, 16'h0003, 1, 0, 0, 0, "push3", 1);
    issue(K_ALU,  4'd0, 16'h0,    1, 1, 1, 16'h0003, 1, 1, 0, 0, "add_depth1", 1);
    issue(K_ALU,  4'd8, 16'h0,    1, 1, 3, 16'h0003, 1, 0, 0, 0, "op8", 1);
    issue(K_ALU,  4'd15, 16'h0,   1, 1, 3, 16'h0003, 1, 0, 0, 0, "op15", 1);
    issue(K_POP,  4'd0, 16'h0,    1, 0, 0, 16'h0000, 0, 0, 0, 0, "pop3", 1);

    // fill to DEPTH, one per cycle
    for (int i = 0; i < 8; i++)
      issue(K_PUSH, 4'd0, 16'h0010 + 16'(i), 1, 0, 0, 16'h0010 + 16'(i), i + 1, 0, 0, 0, "fill", 1);
    issue(K_PUSH, 4'd0, 16'hAAAA, 1, 1, 2, 16'h0017, 8, 0, 0, 0, "push_full", 1);
    issue(K_DUP,  4'd0, 16'h0,    1, 1, 2, 16'h0017, 8, 0, 0, 0, "dup_full", 1);
    issue(K_POP,  4'd0, 16'h0,    1, 0, 0, 16'h0016, 7, 0, 0, 0, "pop_full", 1);
    issue(K_ALU,  4'd0, 16'h0,    2, 0, 0, 16'h002B, 6, 1, 0, 0, "add_deep", 1);

    // reset during EXEC aborts the command
    issue(K_PUSH, 4'd0, 16'h0002, 1, 0, 0, 16'h0002, 7, 0, 0, 0, "push2", 1);
    issue(K_PUSH, 4'd0, 16'h0003, 1, 0, 0, 16'h0003, 8, 0, 0, 0, "push3b", 1);
    issue(K_ALU,  4'd0, 16'h0,    2, 0, 0, 16'h0000, 0, 0, 0, 0, "add_abort", 0);
    chk("abort.ready_in_exec", 32'(cmd_ready), 0);
    RESET_n = 1'b0;
    @(posedge CLK);
    #1;
    chk("abort.depth", 32'(depth), 0);
    chk("abort.tos",   32'(tos), 0);
    chk("abort.done",  32'(done), 0);
    chk("abort.ready_in_reset", 32'(cmd_ready), 0);
    @(posedge CLK);
    #1;
    RESET_n = 1'b1;
    @(posedge CLK);
    #1;
    chk("abort.ready_after_release", 32'(cmd_ready), 1);
    chk("abort.depth_after", 32'(depth), 0);
    chk("abort.tos_after",   32'(tos), 0);

    // cmd_valid held through EXEC/WB is taken once, with its late inputs
    issue(K_PUSH, 4'd0, 16'h0005, 1, 0, 0, 16'h0005, 1, 0, 0, 0, "push5", 1);
    issue(K_ALU,  4'd9, 16'h0,    2, 0, 0, 16'hFFFB, 1, 1, 0, 0, "neg5", 1);
    k = cyc;
    cmd_valid = 1'b1;
    cmd_kind  = K_PUSH;
    cmd_aluop = 4'd8;
    cmd_imm   = 16'h0099;
    push_exp(k + 3, 0, 0, 16'h0099, 2, 0, 0, 0, "held_push");
    repeat (3) @(posedge CLK);
    #1;
    cmd_valid = 1'b0;

    repeat (6) @(negedge CLK);
    chk("sb_drain", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
